// File: rtl/req_encoder16_pkg.sv
// enc_pkg: shared state type, widths and popcount helper for req_encoder16.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;

   localparam int ENC_N      = 16;
   localparam int ENC_CODE_W = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } enc_state_t;

   // Number of set bits in a request vector (16 for all-ones, hence CODE_W+1 bits).
   function automatic logic [ENC_CODE_W:0] popcount16(input logic [ENC_N-1:0] v);
      logic [ENC_CODE_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < ENC_N; i++) begin
         cnt = cnt + {{ENC_CODE_W{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/req_encoder16_prio_enc16.sv
// prio_enc16: combinational lowest-set-bit encoder with any/one-hot flags.
// Latency: zero (purely combinational).
// Backpressure: none; output follows vec.
module prio_enc16
   import enc_pkg::*;
(
   input  logic [ENC_N-1:0]      vec,
   output logic [ENC_CODE_W-1:0] code,
   output logic                  any,
   output logic                  one_hot
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      code = '0;
      for (int i = ENC_N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            code = ENC_CODE_W'(i);
         end
      end
   end

   assign any     = |vec;
   assign one_hot = any && ((vec & (vec - {{(ENC_N-1){1'b0}}, 1'b1})) == '0);

endmodule

// File: rtl/req_encoder16.sv
// req_encoder16: captures a multi-hot vector, emits each set index lowest-first.
// Latency: first code valid the cycle after accept; one code per cycle; one dead cycle between vectors.
// Backpressure: out_ready low holds out_code/out_valid; in_ready low while draining; en low freezes all.
// Optional ENC_COUNT_EN adds the 'remaining' output (codes still to be emitted).
module req_encoder16
   import enc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ENC_N-1:0]      in_vec,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ENC_CODE_W-1:0] out_code,
   output logic                  out_last,
   output logic                  zero_vec,
`ifdef ENC_COUNT_EN
   output logic [ENC_CODE_W:0]   remaining,
`endif
   output logic                  busy
);

   enc_state_t        state_q, state_d;
   logic [ENC_N-1:0]  pend_q, pend_d;
   logic              zero_vec_q, zero_vec_d;
   logic              pend_any;
   logic              pend_one;
   logic              accept;
   logic              out_hs;

   prio_enc16 u_prio (
      .vec     (pend_q),
      .code    (out_code),
      .any     (pend_any),
      .one_hot (pend_one)
   );

   // rst_n gates in_ready so nothing can be accepted while reset is held.
   assign in_ready  = en && rst_n && (state_q == IDLE);
   assign out_valid = en && (state_q == DRAIN) && pend_any;
   assign out_last  = pend_one;
   assign busy      = (state_q == DRAIN);
   assign zero_vec  = zero_vec_q;
   assign accept    = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;

   // Next-state: load on accept, strip the lowest bit on each output handshake.
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      zero_vec_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_vec != '0) begin
                  pend_d  = in_vec;
                  state_d = DRAIN;
               end else begin
                  zero_vec_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (out_hs) begin
               pend_d = pend_q & (pend_q - {{(ENC_N-1){1'b0}}, 1'b1});
               if (pend_one) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            pend_d  = '0;
         end
      endcase
   end

   // State registers; reset drops any pending work immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         zero_vec_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         zero_vec_q <= zero_vec_d;
      end
   end

`ifdef ENC_COUNT_EN
   logic [ENC_CODE_W:0] remaining_q, remaining_d;

   // Remaining-code counter: popcount on accept, minus one per handshake.
   always_comb begin
      remaining_d = remaining_q;
      if (accept) begin
         remaining_d = popcount16(in_vec);
      end else if (out_hs) begin
         remaining_d = remaining_q - {{ENC_CODE_W{1'b0}}, 1'b1};
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining_q <= '0;
      end else begin
         remaining_q <= remaining_d;
      end
   end

   assign remaining = remaining_q;
`endif

endmodule

// File: tb/tb_req_encoder16.sv
// tb_req_encoder16: directed scenarios against hand-computed code sequences.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: exercised via out_ready and en scenarios.
module tb_req_encoder16;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_vec;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_code;
   logic        out_last;
   logic        zero_vec;
   logic        busy;
`ifdef ENC_COUNT_EN
   logic [4:0]  remaining;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   req_encoder16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .zero_vec  (zero_vec),
`ifdef ENC_COUNT_EN
      .remaining (remaining),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present v until in_ready, then take the accepting edge and drop in_valid.
   task automatic send_vec(input logic [15:0] v);
      int n;
      in_valid = 1'b1;
      in_vec   = v;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      n_checks++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_ready_timeout got in_ready=%0b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
      #3;
      n_checks++;
      if ({in_ready, out_valid, out_code, out_last, zero_vec, busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got rdy=%0b vld=%0b code=%0d last=%0b zero=%0b busy=%0b exp all 0",
                  in_ready, out_valid, out_code, out_last, zero_vec, busy);
      end
`ifdef ENC_COUNT_EN
      n_checks++;
      if (remaining !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_remaining got %0d exp 0", remaining);
      end
`endif
      #19 rst_n = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_ready got %0b exp 1", in_ready);
      end
   endtask

   task automatic test_multihot();
      int exp_codes[4] = '{0, 5, 10, 15};
      out_ready = 1'b1;
      send_vec(16'h8421);
`ifdef ENC_COUNT_EN
      n_checks++;
      if (remaining !== 5'd4) begin
         n_fail++;
         $display("FAIL mh_remaining got %0d exp 4", remaining);
      end
`endif
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_code !== 4'(exp_codes[i]) || out_last !== (i == 3) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mh_code%0d got vld=%0b code=%0d last=%0b busy=%0b exp vld=1 code=%0d last=%0b busy=1",
                     i, out_valid, out_code, out_last, busy, exp_codes[i], (i == 3));
         end
         tick();
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mh_after got rdy=%0b vld=%0b busy=%0b exp rdy=1 vld=0 busy=0", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_vec(16'h0006);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_code !== 4'd1 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d got vld=%0b code=%0d last=%0b exp vld=1 code=1 last=0",
                     i, out_valid, out_code, out_last);
         end
         tick();
      end
      out_ready = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || out_code !== 4'd1 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_code1 got vld=%0b code=%0d last=%0b exp 1/1/0", out_valid, out_code, out_last);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_code !== 4'd2 || out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_code2 got vld=%0b code=%0d last=%0b exp 1/2/1", out_valid, out_code, out_last);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_after got vld=%0b rdy=%0b exp vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_zero();
      out_ready = 1'b1;
      n_checks++;
      if (zero_vec !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_before got %0b exp 0", zero_vec);
      end
      send_vec(16'h0000);
      n_checks++;
      if (zero_vec !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_pulse got zero=%0b vld=%0b rdy=%0b busy=%0b exp 1/0/1/0",
                  zero_vec, out_valid, in_ready, busy);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (zero_vec !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_after%0d got zero=%0b vld=%0b rdy=%0b exp 0/0/1",
                     i, zero_vec, out_valid, in_ready);
         end
         tick();
      end
   endtask

   task automatic test_enable_freeze();
      int cnt;
      cnt = 0;
      out_ready = 1'b1;
      send_vec(16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_code !== 4'(i) || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL frz_pre%0d got vld=%0b code=%0d last=%0b exp 1/%0d/0",
                     i, out_valid, out_code, out_last, i);
         end
         if (out_valid) cnt++;
         tick();
      end
      en = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_code !== 4'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frz_hold%0d got vld=%0b rdy=%0b code=%0d busy=%0b exp 0/0/4/1",
                     i, out_valid, in_ready, out_code, busy);
         end
`ifdef ENC_COUNT_EN
         n_checks++;
         if (remaining !== 5'd12) begin
            n_fail++;
            $display("FAIL frz_remaining%0d got %0d exp 12", i, remaining);
         end
`endif
         tick();
      end
      en = 1'b1;
      #1;
      for (int i = 4; i < 16; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_code !== 4'(i) || out_last !== (i == 15)) begin
            n_fail++;
            $display("FAIL frz_post%0d got vld=%0b code=%0d last=%0b exp 1/%0d/%0b",
                     i, out_valid, out_code, out_last, i, (i == 15));
         end
         if (out_valid) cnt++;
         tick();
      end
      n_checks++;
      if (cnt != 16 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL frz_total got %0d codes vld=%0b exp 16 codes vld=0", cnt, out_valid);
      end
   endtask

   task automatic test_ignore_during_drain();
      out_ready = 1'b1;
      send_vec(16'h0300);
      in_valid = 1'b1;
      in_vec   = 16'h00FF;
      n_checks++;
      if (out_valid !== 1'b1 || out_code !== 4'd8 || out_last !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_code8 got vld=%0b code=%0d last=%0b rdy=%0b exp 1/8/0/0",
                  out_valid, out_code, out_last, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_code !== 4'd9 || out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL ign_code9 got vld=%0b code=%0d last=%0b exp 1/9/1", out_valid, out_code, out_last);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ign_dead got vld=%0b rdy=%0b exp 0/1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_code !== 4'(i) || out_last !== (i == 7)) begin
            n_fail++;
            $display("FAIL ign_next%0d got vld=%0b code=%0d last=%0b exp 1/%0d/%0b",
                     i, out_valid, out_code, out_last, i, (i == 7));
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_drain();
      out_ready = 1'b1;
      send_vec(16'h00F0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_code !== 4'(4 + i)) begin
            n_fail++;
            $display("FAIL rmd_code%0d got vld=%0b code=%0d exp 1/%0d", i, out_valid, out_code, 4 + i);
         end
         tick();
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_code !== 4'd0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rmd_in_reset got vld=%0b busy=%0b code=%0d rdy=%0b exp 0/0/0/0",
                  out_valid, busy, out_code, in_ready);
      end
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rmd_released got vld=%0b busy=%0b exp 0/0", out_valid, busy);
      end
      send_vec(16'h0001);
      n_checks++;
      if (out_valid !== 1'b1 || out_code !== 4'd0 || out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL rmd_single got vld=%0b code=%0d last=%0b exp 1/0/1", out_valid, out_code, out_last);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rmd_done got vld=%0b rdy=%0b exp 0/1", out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_multihot();
      test_backpressure();
      test_zero();
      test_enable_freeze();
      test_ignore_during_drain();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/req_encoder16.md
# req_encoder16

Sequential 16-to-4 request encoder: the inverse of the lab 4-to-16 decoder. It captures a 16-bit multi-hot request vector and emits the 4-bit index of every set bit, lowest index first, one code per accepted output handshake. It sits between a request-vector source (switch bank, interrupt lines, decoder outputs) and a consumer that takes one binary code at a time.

## Interface
- N, 16, request vector width; power of two, ≥ 2.
- CODE_W, $clog2(N), code width; derived, never overridden.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  global enable. When low, the block freezes and raises no handshakes.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  the block can accept a vector.
- in_vec  input  N  request vector.
- out_valid  output  1  out_code holds a valid index.
- out_ready  input  1  the consumer accepts out_code.
- out_code  output  CODE_W  index of the lowest pending bit.
- out_last  output  1  out_code is the final pending index of the current vector.
- zero_vec  output  1  one-cycle pulse when an all-zero vector is accepted.
- busy  output  1  in the DRAIN state.

## Operation
- Registers:
  - state: IDLE or DRAIN.
  - pend[N-1:0]: pending bits.
  - zero_vec flop.
- IDLE:
  - in_ready = en.
  - A vector is accepted on an edge where in_valid & in_ready.
  - If in_vec ≠ 0: pend ← in_vec, go to DRAIN.
  - If in_vec = 0: stay in IDLE, pend stays 0, zero_vec = 1 for the next cycle only.
- DRAIN:
  - in_ready = 0.
  - out_valid = en.
  - out_code = index of the lowest set bit of pend.
  - out_last = 1 when exactly one bit of pend is set.
  - On out_valid & out_ready: clear that bit in pend. If out_last was 1, go to IDLE.
- en low: all state holds, in_ready = 0, out_valid = 0. out_code/out_last keep reflecting pend. Draining resumes unchanged when en returns high.
- A vector with k set bits produces exactly k codes, strictly ascending, with out_last on the k-th code only.
- in_vec = 16'hFFFF produces codes 0..15.
- in_vec changes while in DRAIN are ignored.
- out_valid never drops without a handshake while en is high, and out_code stays stable while out_valid & !out_ready.
- busy = (state == DRAIN).

## Timing
- Reset values: state = IDLE, pend = 0, in_ready = 0 during reset (then = en), out_valid = 0, out_code = 0, out_last = 0, zero_vec = 0, busy = 0.
- Assertion of rst_n low mid-drain discards pend immediately; no further codes are emitted.
- Latency: vector accepted at edge E → out_valid high in the cycle after E (edge E+1 can complete the first handshake).
- Throughput: one code per cycle with out_ready held high.
- Back-to-back vectors: the last handshake at edge L returns to IDLE. in_ready is high after L, so the next vector is accepted no earlier than edge L+1.
- Dead cycle between vectors: one.
- All outputs are functions of registers and en only. There is no combinational path from in_valid/in_vec or out_ready to any output.

## Configuration
- ENC_COUNT_EN defined:
  - Adds output port remaining (CODE_W+1 bits).
  - It loads popcount(in_vec) on accept (16 for all-ones).
  - It decrements by 1 on each output handshake and is 0 in IDLE and at reset.
  - Held while en is low.
- ENC_COUNT_EN undefined: port and popcount logic absent; all other behaviour identical.

## Structure
- Package enc_pkg holds:
  - state typedef enc_state_t {IDLE, DRAIN};
  - constants ENC_N = 16 and ENC_CODE_W = 4.
- Sub-module prio_enc16: purely combinational, vec[15:0] → code[3:0] (lowest set index), any (vec ≠ 0), one_hot (exactly one bit set). The top instantiates it on pend.

## Test plan
- Reset mid-drain: load 16'h00F0, complete 2 handshakes, pulse rst_n low → out_valid = 0, busy = 0 immediately; after release the next vector 16'h0001 yields the single code 0 with out_last = 1.
- Multi-hot, no backpressure: in_vec = 16'h8421, out_ready = 1 → codes 0, 5, 10, 15 on consecutive cycles, out_last only on 15, in_ready high one cycle after.
- Backpressure: in_vec = 16'h0006, out_ready low for 3 cycles → out_code held at 1 with out_valid high, then codes 1, 2.
- Zero vector: in_vec = 0 accepted → zero_vec high for exactly one cycle, out_valid never asserts, in_ready stays high.
- Enable freeze: in_vec = 16'hFFFF, drop en after code 3 for 4 cycles → no handshakes, out_valid = 0. Resume yields 4..15, 16 codes total. With ENC_COUNT_EN, remaining reads 12 during the freeze.
- Input ignored during drain: change in_vec and hold in_valid high while draining 16'h0300 → only codes 8, 9 are emitted; the new vector is accepted one cycle after out_last.
